ram_ctrl: RTL and testbench

Burst sequencer that sits directly upstream of the asynchronous RAM and drives its `direccion`, `Dato_E` and `EN` inputs while capturing its `dato_s` output. On a start command it runs one write burst or one read burst over `longitud` consecutive addresses beginning at `dir_ini`, wrapping at the end of the RAM. Write data enters through a valid/ready stream and read data leaves through one. Write pulses are sequenced so that the address is stable whenever `EN` is high.

---
 rtl/ram_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ram_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: write/read burst sequencer in front of an asynchronous RAM, wrapping at PROF-1.
// Define RAM_CTRL_CHECKSUM_EN to enable the running checksum on suma; otherwise suma is tied to 0.
module ram_ctrl #(
    parameter int ANCHO     = 8,
    parameter int DIR_ANCHO = 8,
    parameter int PROF      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio,
    input  logic                 modo,
    input  logic [DIR_ANCHO-1:0] dir_ini,
    input  logic [DIR_ANCHO-1:0] longitud,
    input  logic [ANCHO-1:0]     dato_in,
    input  logic                 valido_in,
    output logic                 listo_in,
    output logic [ANCHO-1:0]     dato_out,
    output logic                 valido_out,
    input  logic                 listo_out,
    output logic [DIR_ANCHO-1:0] direccion,
    output logic [ANCHO-1:0]     Dato_E,
    output logic                 EN,
    input  logic [ANCHO-1:0]     dato_s,
    output logic                 ocupado,
    output logic                 fin,
    output logic [ANCHO-1:0]     suma,
    output logic [2:0]           estado_dbg
);

    typedef enum logic [2:0] {
        IDLE, ESCRIBIR, PULSO, AVANZA, LEER, CAPTURA, MOSTRAR, FIN
    } estado_t;

    localparam logic [DIR_ANCHO-1:0] ULTIMA = DIR_ANCHO'(PROF - 1);
    localparam logic [DIR_ANCHO-1:0] UNO    = DIR_ANCHO'(1);

    estado_t              estado, estado_d;
    logic [DIR_ANCHO-1:0] ptr, ptr_d, ptr_sig;
    logic [DIR_ANCHO-1:0] cnt, cnt_d;
    logic [ANCHO-1:0]     dato_e_d, dato_out_d;
    logic                 en_d, listo_in_d, valido_out_d, ocupado_d, fin_d;
    logic                 wr_hs, rd_hs;

    // Both streams: a word moves on a rising edge where valid and ready are both high;
    // the producer keeps valid and data steady until that edge.
    assign wr_hs = (estado == ESCRIBIR) && valido_in && listo_in;
    assign rd_hs = (estado == MOSTRAR) && valido_out && listo_out;

    assign ptr_sig    = (ptr == ULTIMA) ? '0 : ptr + UNO;
    assign direccion  = ptr;
    assign estado_dbg = estado;

    always_comb begin
        estado_d     = estado;
        ptr_d        = ptr;
        cnt_d        = cnt;
        dato_e_d     = Dato_E;
        en_d         = 1'b0;
        listo_in_d   = listo_in;
        dato_out_d   = dato_out;
        valido_out_d = valido_out;
        ocupado_d    = ocupado;
        fin_d        = 1'b0;
        case (estado)
            IDLE: begin
                if (inicio) begin
                    ocupado_d = 1'b1;
                    ptr_d     = (dir_ini > ULTIMA) ? '0 : dir_ini;
                    cnt_d     = longitud;
                    if (longitud == '0) begin
                        estado_d = FIN;
                    end else if (modo) begin
                        estado_d = LEER;
                    end else begin
                        estado_d   = ESCRIBIR;
                        listo_in_d = 1'b1;
                    end
                end
            end
            ESCRIBIR: begin
                if (wr_hs) begin
                    dato_e_d   = dato_in;
                    en_d       = 1'b1;
                    listo_in_d = 1'b0;
                    estado_d   = PULSO;
                end
            end
            // EN drops here so the address only moves one cycle after the pulse ends.
            PULSO: estado_d = AVANZA;
            AVANZA: begin
                ptr_d = ptr_sig;
                cnt_d = cnt - UNO;
                if (cnt == UNO) begin
                    estado_d = FIN;
                end else begin
                    estado_d   = ESCRIBIR;
                    listo_in_d = 1'b1;
                end
            end
            LEER: estado_d = CAPTURA;
            CAPTURA: begin
                dato_out_d   = dato_s;
                valido_out_d = 1'b1;
                estado_d     = MOSTRAR;
            end
            MOSTRAR: begin
                if (rd_hs) begin
                    valido_out_d = 1'b0;
                    ptr_d        = ptr_sig;
                    cnt_d        = cnt - UNO;
                    estado_d     = (cnt == UNO) ? FIN : LEER;
                end
            end
            FIN: begin
                fin_d     = 1'b1;
                ocupado_d = 1'b0;
                estado_d  = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado     <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            Dato_E     <= '0;
            EN         <= 1'b0;
            listo_in   <= 1'b0;
            dato_out   <= '0;
            valido_out <= 1'b0;
            ocupado    <= 1'b0;
            fin        <= 1'b0;
        end else begin
            estado     <= estado_d;
            ptr        <= ptr_d;
            cnt        <= cnt_d;
            Dato_E     <= dato_e_d;
            EN         <= en_d;
            listo_in   <= listo_in_d;
            dato_out   <= dato_out_d;
            valido_out <= valido_out_d;
            ocupado    <= ocupado_d;
            fin        <= fin_d;
        end
    end

`ifdef RAM_CTRL_CHECKSUM_EN
    logic [ANCHO-1:0] suma_q, suma_d;

    always_comb begin
        suma_d = suma_q;
        if (estado == IDLE && inicio) begin
            suma_d = '0;
        end else if (wr_hs) begin
            suma_d = suma_q + dato_in;
        end else if (rd_hs) begin
            suma_d = suma_q + dato_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            suma_q <= '0;
        end else begin
            suma_q <= suma_d;
        end
    end

    assign suma = suma_q;
`else
    assign suma = '0;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: randomized write/read bursts against a word-level model of RAM contents,
// stream traffic, burst latencies and the optional checksum.
`timescale 1ns/1ps
module tb_ram_ctrl;
    localparam int ANCHO     = 8;
    localparam int DIR_ANCHO = 8;
    localparam int PROF      = 11;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 inicio = 1'b0;
    logic                 modo = 1'b0;
    logic [DIR_ANCHO-1:0] dir_ini = '0;
    logic [DIR_ANCHO-1:0] longitud = '0;
    logic [ANCHO-1:0]     dato_in = '0;
    logic                 valido_in = 1'b0;
    logic                 listo_in;
    logic [ANCHO-1:0]     dato_out;
    logic                 valido_out;
    logic                 listo_out = 1'b0;
    logic [DIR_ANCHO-1:0] direccion;
    logic [ANCHO-1:0]     Dato_E;
    logic                 EN;
    logic [ANCHO-1:0]     dato_s;
    logic                 ocupado;
    logic                 fin;
    logic [ANCHO-1:0]     suma;
    logic [2:0]           estado_dbg;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ram_ctrl #(.ANCHO(ANCHO), .DIR_ANCHO(DIR_ANCHO), .PROF(PROF)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .modo(modo), .dir_ini(dir_ini),
        .longitud(longitud), .dato_in(dato_in), .valido_in(valido_in), .listo_in(listo_in),
        .dato_out(dato_out), .valido_out(valido_out), .listo_out(listo_out),
        .direccion(direccion), .Dato_E(Dato_E), .EN(EN), .dato_s(dato_s),
        .ocupado(ocupado), .fin(fin), .suma(suma), .estado_dbg(estado_dbg)
    );

    // ---------------- RAM, model and scoreboard state ----------------
    logic [ANCHO-1:0] ram     [0:255];
    logic [ANCHO-1:0] ref_mem [0:255];
    logic [ANCHO-1:0] exp_q[$];
    logic [7:0]       en_addr_q[$];
    logic [ANCHO-1:0] en_data_q[$];
    logic [ANCHO-1:0] wdata_q[$];
    logic [ANCHO-1:0] exp_suma = '0;
    int               errors = 0;
    int               checks = 0;
    int               en_cnt = 0;
    int               fin_cnt = 0;
    int               bursts_done = 0;
    logic             prev_en = 1'b0;

    assign dato_s = ram[direccion];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] start_of(input int dir);
        return (dir >= PROF) ? 8'd0 : 8'(dir);
    endfunction

    function automatic logic [7:0] addr_at(input logic [7:0] s, input int i);
        return 8'((int'(s) + i) % PROF);
    endfunction

    function automatic logic [ANCHO-1:0] suma_exp();
`ifdef RAM_CTRL_CHECKSUM_EN
        return exp_suma;
`else
        return '0;
`endif
    endfunction

    // The asynchronous RAM plus a monitor of every write pulse it sees.
    always @(negedge clk) begin
        if (EN === 1'b1) begin
            en_cnt++;
            check("en_single_cycle", prev_en, 0);
            if (en_addr_q.size() == 0) begin
                check("en_unexpected", EN, 0);
            end else begin
                check("en_addr", direccion, en_addr_q.pop_front());
                check("en_data", Dato_E, en_data_q.pop_front());
            end
            ram[direccion] = Dato_E;
        end
        if (fin === 1'b1) fin_cnt++;
        prev_en = EN;
    end

    // ---------------- driver tasks ----------------
    task automatic start_burst(input bit m, input int dir, input int len);
        inicio = 1'b1; modo = m; dir_ini = 8'(dir); longitud = 8'(len);
        exp_suma = '0;
        @(negedge clk);
        inicio = 1'b0; modo = 1'($urandom); dir_ini = 8'($urandom); longitud = 8'($urandom);
        check("busy", ocupado, 1);
        check("fin_low", fin, 0);
        check("fin_pulses", fin_cnt, bursts_done);
        check("start_addr", direccion, start_of(dir));
        check("listo_in_start", listo_in, (len > 0 && !m) ? 1 : 0);
        check("valido_out_start", valido_out, 0);
    endtask

    task automatic wait_fin(input int exp_lat);
        int n = 0;
        while (fin !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("fin_latency", n, exp_lat);
        check("fin_ocupado", ocupado, 0);
        check("fin_valido", valido_out, 0);
        check("fin_suma", suma, suma_exp());
        bursts_done++;
    endtask

    task automatic write_word(input logic [7:0] addr, input logic [ANCHO-1:0] data, input int gap_exp);
        int waited = 0;
        en_addr_q.push_back(addr);
        en_data_q.push_back(data);
        ref_mem[addr] = data;
        exp_suma = exp_suma + data;
        while (listo_in !== 1'b1 && waited < 40) begin
            valido_in = 1'($urandom_range(0, 1));
            dato_in   = 8'($urandom);
            @(negedge clk);
            waited++;
        end
        if (gap_exp >= 0) check("listo_in_gap", waited, gap_exp);
        check("listo_in_up", listo_in, 1);
        while ($urandom_range(0, 2) == 0) begin
            valido_in = 1'b0;
            @(negedge clk);
        end
        valido_in = 1'b1; dato_in = data;
        @(negedge clk);
        valido_in = 1'b0; dato_in = 8'($urandom);
        check("listo_in_drop", listo_in, 0);
        check("en_high", EN, 1);
    endtask

    task automatic read_word(input logic [7:0] addr, input int stall, input bit poke);
        logic [ANCHO-1:0] exp_d;
        int lat = 1;
        exp_d = exp_q.pop_front();
        while (valido_out !== 1'b1 && lat < 30) begin
            listo_out = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        check("read_latency", lat, 3);
        check("read_addr", direccion, addr);
        check("read_data", dato_out, exp_d);
        for (int s = 0; s < stall; s++) begin
            listo_out = 1'b0;
            if (poke && s == 1) begin
                inicio = 1'b1; modo = 1'b0; dir_ini = 8'($urandom); longitud = 8'($urandom);
            end
            @(negedge clk);
            inicio = 1'b0;
            check("hold_valid", valido_out, 1);
            check("hold_data", dato_out, exp_d);
            check("hold_addr", direccion, addr);
        end
        listo_out = 1'b1;
        @(negedge clk);
        listo_out = 1'b0;
        check("valid_drop", valido_out, 0);
        exp_suma = exp_suma + exp_d;
    endtask

    task automatic run_write(input int dir, input int len);
        logic [7:0] s;
        logic [ANCHO-1:0] d;
        s = start_of(dir);
        start_burst(1'b0, dir, len);
        for (int i = 0; i < len; i++) begin
            d = (wdata_q.size() > 0) ? wdata_q.pop_front() : 8'($urandom);
            write_word(addr_at(s, i), d, (i == 0) ? -1 : 2);
        end
        wait_fin((len > 0) ? 3 : 1);
    endtask

    task automatic run_read(input int dir, input int len, input int stall_word,
                            input int stall_len, input bit poke, input bit rnd);
        logic [7:0] s;
        s = start_of(dir);
        for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[addr_at(s, i)]);
        start_burst(1'b1, dir, len);
        for (int i = 0; i < len; i++) begin
            read_word(addr_at(s, i),
                      (i == stall_word) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0),
                      poke && (i == stall_word));
        end
        wait_fin(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int en_before;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'(90 - 10 * i);
            ref_mem[i] = 8'(90 - 10 * i);
        end

        repeat (3) @(negedge clk);
        check("rst_direccion", direccion, 0);
        check("rst_dato_e", Dato_E, 0);
        check("rst_en", EN, 0);
        check("rst_dato_out", dato_out, 0);
        check("rst_valido_out", valido_out, 0);
        check("rst_listo_in", listo_in, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_fin", fin, 0);
        check("rst_suma", suma, 0);
        rst = 1'b0;
        @(negedge clk);

        run_read(0, 3, -1, 0, 1'b0, 1'b0);
        run_read(0, 3, 1, 5, 1'b1, 1'b0);

        en_before = en_cnt;
        run_write(4, 0);
        run_read(5, 0, -1, 0, 1'b0, 1'b0);
        check("len0_no_en", en_cnt, en_before);
        run_read(20, 1, -1, 0, 1'b0, 1'b0);

        wdata_q = '{8'd1, 8'd2, 8'd3};
        run_write(9, 3);
        run_read(9, 3, -1, 0, 1'b0, 1'b0);

        start_burst(1'b0, 3, 4);
        write_word(8'd3, 8'h11, -1);
        n = 0;
        while (listo_in !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_listo", listo_in, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_suma = '0;
        check("mid_rst_direccion", direccion, 0);
        check("mid_rst_dato_e", Dato_E, 0);
        check("mid_rst_en", EN, 0);
        check("mid_rst_dato_out", dato_out, 0);
        check("mid_rst_valido_out", valido_out, 0);
        check("mid_rst_listo_in", listo_in, 0);
        check("mid_rst_ocupado", ocupado, 0);
        check("mid_rst_fin", fin, 0);
        check("mid_rst_suma", suma, 0);
        @(negedge clk);
        run_read(2, 3, -1, 0, 1'b0, 1'b0);

        en_before = en_cnt;
        wdata_q = '{8'd5, 8'd7};
        run_write(4, 2);
        check("two_en_pulses", en_cnt - en_before, 2);
        run_read(4, 2, -1, 0, 1'b0, 1'b1);

        for (int t = 0; t < 24; t++) begin
            int d;
            int l;
            d = $urandom_range(0, 14);
            l = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) begin
                run_write(d, l);
            end else begin
                run_read(d, l, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("en_all_seen", en_addr_q.size(), 0);
        check("reads_all_seen", exp_q.size(), 0);
        check("fin_total", fin_cnt, bursts_done);
        for (int i = 0; i < PROF; i++) check("ram_final", ram[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
